shift_unit_seq: RTL

//  Parametrised multi-mode iterative shifter for the integer ALU datapath.

---
 rtl/shift_unit_seq_if.sv | 15 +
 rtl/shift_unit_seq.sv | 67 ++++++
 2 files changed

// File: rtl/shift_unit_seq_if.sv
// shift_unit_seq_if: start/busy/done request bundle between an ALU controller and the iterative shifter
interface shift_unit_seq_if #(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             start;
  logic [1:0]       mode;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  modport master (output start, mode, shamt, din, input busy, done, dout);
  modport slave  (input start, mode, shamt, din, output busy, done, dout);
endinterface

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: iterative SRL/SLL/SRA/ROR shifter, one bit position per clock
module shift_unit_seq #(
  parameter  int WIDTH = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic              clk,
  input logic              rst_n,
  shift_unit_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SRL, SLL, SRA, ROR} mode_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, dout_q, dout_d, step;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  // one-bit step of the working register for the latched mode
  always_comb begin
    step = mode_q == SRL ? {1'b0, sreg_q[WIDTH-1:1]} :
           mode_q == SLL ? {sreg_q[WIDTH-2:0], 1'b0} :
           mode_q == SRA ? {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]} :
                           {sreg_q[0], sreg_q[WIDTH-1:1]};
  end
  // next state: operands captured only in IDLE so requests while busy are ignored
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        sreg_d  = bus.din;
        cnt_d   = bus.shamt;
        mode_d  = bus.mode;
        state_d = SHIFT;
      end
      SHIFT: if (cnt_q != '0) begin
        sreg_d = step;
        cnt_d  = cnt_q - 1'b1;
      end else begin
        dout_d  = sreg_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset aborts any operation without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.dout = dout_q;
endmodule
